wb_stream_master: RTL

WB_STREAM_MASTER -- requirements
Module: wb_stream_master

---
 rtl/wb_stream_pkg.sv | 45 ++++
 rtl/wb_stream_master_if.sv | 32 +++
 rtl/wb_timeout_counter.sv | 35 +++
 rtl/wb_stream_master.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wb_stream_pkg.sv
// Shared encodings, message field offsets and address helper for the Wishbone
// stream master.
package wb_stream_pkg;

    typedef enum logic [1:0] {
        CMD_INSTR = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_STORE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_BADCMD  = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;

    localparam int CMD_W         = 64;
    localparam int RESP_W        = 34;
    localparam int CMD_TYPE_LSB  = 62;
    localparam int CMD_IDX_LSB   = 32;
    localparam int CMD_IDX_W     = 30;
    localparam int CMD_DATA_LSB  = 0;
    localparam int DATA_W        = 32;

    // Instruction port sits at the base; data words start one word above it.
    function automatic logic [31:0] cmd_addr(input logic [31:0] base,
                                             input cmd_type_e   typ,
                                             input logic [29:0] idx);
        return (typ == CMD_INSTR) ? base : base + 32'd4 + {idx, 2'b00};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_stream_master_if.sv
// Command/response stream plus Wishbone master bus bundle.
interface wb_stream_master_if
    import wb_stream_pkg::*;
;
    logic [CMD_W-1:0]  cmd_msg;
    logic              cmd_val;
    logic              cmd_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [31:0]       wbm_adr_o;
    logic [31:0]       wbm_dat_o;
    logic [31:0]       wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_msg, cmd_val, resp_rdy, wbm_dat_i, wbm_ack_i,
        output cmd_rdy, resp_msg, resp_val,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_msg, cmd_val, resp_rdy, wbm_dat_i, wbm_ack_i,
        input  cmd_rdy, resp_msg, resp_val,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Bus-request wait counter; expired flags the last cycle a request may wait.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/wb_stream_master.sv
// Turns a command stream into single Wishbone transfers and returns one
// status/data response per command.
//
// state  | meaning
// IDLE   | cmd_rdy high, waiting for a command
// REQ    | Wishbone cycle in flight, waiting for ack or timeout
// RESP   | response held on resp_msg until resp_rdy
module wb_stream_master
    import wb_stream_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_stream_master_if.master bus,
    output logic [7:0]         err_count
);

    state_e            state_q, state_d;
    cmd_type_e         typ_q, typ_d, cmd_typ;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              resp_val_q, resp_val_d;
    logic [RESP_W-1:0] resp_msg_q, resp_msg_d;
    logic [7:0]        err_q, err_d;
    logic              tmo_clr, tmo_en, tmo_expired;

    assign cmd_typ = cmd_type_e'(bus.cmd_msg[CMD_TYPE_LSB +: 2]);

    wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (tmo_clr),
        .enable   (tmo_en),
        .expired  (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        typ_d      = typ_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        resp_val_d = resp_val_q;
        resp_msg_d = resp_msg_q;
        err_d      = err_q;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_val) begin
                    typ_d = cmd_typ;
                    if (cmd_typ == CMD_RSVD) begin
                        state_d    = S_RESP;
                        resp_val_d = 1'b1;
                        resp_msg_d = {ST_BADCMD, 32'h0};
                        err_d      = sat_inc8(err_q);
                    end else begin
                        state_d = S_REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = 4'hF;
                        adr_d   = cmd_addr(BASE_ADDR, cmd_typ,
                                           bus.cmd_msg[CMD_IDX_LSB +: CMD_IDX_W]);
                        // Only STORE reads the slave; INSTR and LOAD push data out.
                        we_d    = (cmd_typ != CMD_STORE);
                        dat_d   = (cmd_typ == CMD_STORE) ? 32'h0
                                                         : bus.cmd_msg[CMD_DATA_LSB +: DATA_W];
                        tmo_clr = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (bus.wbm_ack_i || tmo_expired) begin
                    state_d    = S_RESP;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    adr_d      = 32'h0;
                    dat_d      = 32'h0;
                    resp_val_d = 1'b1;
                    if (bus.wbm_ack_i) begin
                        resp_msg_d = {ST_OK, (typ_q == CMD_STORE) ? bus.wbm_dat_i : 32'h0};
                    end else begin
                        resp_msg_d = {ST_TIMEOUT, 32'h0};
                        err_d      = sat_inc8(err_q);
                    end
                end else begin
                    tmo_en = 1'b1;
                end
            end

            S_RESP: begin
                if (bus.resp_rdy) begin
                    state_d    = S_IDLE;
                    resp_val_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            typ_q      <= CMD_INSTR;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            resp_val_q <= 1'b0;
            resp_msg_q <= '0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            typ_q      <= typ_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            resp_val_q <= resp_val_d;
            resp_msg_q <= resp_msg_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_rdy   = (state_q == S_IDLE);
    assign bus.resp_val  = resp_val_q;
    assign bus.resp_msg  = resp_msg_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign err_count     = err_q;

endmodule
